// File: rtl/adder_req_arbiter.sv
// rtl/adder_req_arbiter.sv - round-robin arbiter sharing one combinational adder among requesters
//
// Purpose: accepts operand pairs from NumReq requesters (round-robin), drives
// the shared adder inputs from registers, captures the sum plus carry-out and
// returns it tagged with the owner index over one valid/ready response channel.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_valid_i  per-requester request valid
//   req_a_i      packed operand A, requester k at [k*Width +: Width]
//   req_b_i      packed operand B, same packing
//   req_ready_o  one-hot accept strobe (combinational, IDLE only)
//   adder_a_o    registered adder operand A
//   adder_b_o    registered adder operand B
//   adder_c_i    adder sum (A+B) mod 2^Width
//   rsp_valid_o  result valid
//   rsp_ready_i  result consumer ready
//   rsp_c_o      captured sum
//   rsp_ovf_o    unsigned carry-out of the sum
//   rsp_id_o     owner of the result
//   busy_o       high whenever not IDLE
module adder_req_arbiter #(
    parameter int Width  = 8,
    parameter int NumReq = 4,
    parameter int IdW    = $clog2(NumReq)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq-1:0]        req_valid_i,
    input  logic [NumReq*Width-1:0]  req_a_i,
    input  logic [NumReq*Width-1:0]  req_b_i,
    output logic [NumReq-1:0]        req_ready_o,
    output logic [Width-1:0]         adder_a_o,
    output logic [Width-1:0]         adder_b_o,
    input  logic [Width-1:0]         adder_c_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [Width-1:0]         rsp_c_o,
    output logic                     rsp_ovf_o,
    output logic [IdW-1:0]           rsp_id_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [IdW-1:0]     last_grant;
    logic [IdW-1:0]     cand;
    logic [IdW-1:0]     win_idx;
    logic               win_found;
    logic [Width-1:0]   win_a;
    logic [Width-1:0]   win_b;
    logic               accept;

    // Search upward from last_grant+1, wrapping at NumReq (which need not be
    // a power of two), and keep the first asserted request.
    always_comb begin
        cand      = last_grant;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = (cand == IdW'(NumReq - 1)) ? '0 : cand + 1'b1;
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (win_idx == IdW'(k)) begin
                win_a = req_a_i[k*Width +: Width];
                win_b = req_b_i[k*Width +: Width];
            end
        end
    end

    // Reset takes priority over an accept, so the strobe is masked by rst_i.
    assign accept = (state == IDLE) && win_found && !rst_i;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= IdW'(NumReq - 1);
            adder_a_o   <= '0;
            adder_b_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_c_o     <= '0;
            rsp_ovf_o   <= 1'b0;
            rsp_id_o    <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        adder_a_o  <= win_a;
                        adder_b_o  <= win_b;
                        rsp_id_o   <= win_idx;
                        last_grant <= win_idx;
                        busy_o     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_c_o     <= adder_c_i;
                    // A wrapped sum is smaller than either operand exactly when
                    // a carry left the top bit.
                    rsp_ovf_o   <= (adder_c_i < adder_a_o);
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
